// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32 execute stage: operand forwarding, ALU with shift-add multiplier, branch resolution, EX/MEM slot
//
// Purpose:
//   Takes the decoded ID/EX slot and forwards operands from MEM/WB. It evaluates the ALU, or
//   runs a DATA_WIDTH-cycle shift-add multiply for mul/mulhu. It resolves branches and jumps,
//   and registers the result into the EX/MEM slot. While a multiply is in flight, ex_ready
//   stays low and decode holds its outputs.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   ex_valid / ex_ready             ID/EX slot handshake; ex_ready low stalls decode
//   RegWrite..BranchInv, ResultSrc  decoded controls
//   ALUctrl                         ALU opcode (0 add .. 9 sra, 10 mul, 11 mulhu)
//   rs1, rs2, rd                    register indices
//   RD1, RD2, ImmOp, PC, PCPlus4    operands from decode
//   mem_*, wb_*                     forwarding sources
//   PCSrc, PCTarget                 combinational fetch redirect
//   m_*                             registered EX/MEM slot
module execute_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUctrl_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic                     RegWrite,
  input  logic                     MemWrite,
  input  logic                     ALUsrc,
  input  logic                     JALRctrl,
  input  logic                     Jump,
  input  logic                     Branch,
  input  logic                     BranchInv,
  input  logic [1:0]               ResultSrc,
  input  logic [ALUctrl_WIDTH-1:0] ALUctrl,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]    RD1,
  input  logic [DATA_WIDTH-1:0]    RD2,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic [DATA_WIDTH-1:0]    PC,
  input  logic [DATA_WIDTH-1:0]    PCPlus4,
  input  logic                     mem_RegWrite,
  input  logic                     wb_RegWrite,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic                     PCSrc,
  output logic [DATA_WIDTH-1:0]    PCTarget,
  output logic                     m_valid,
  output logic                     m_RegWrite,
  output logic                     m_MemWrite,
  output logic [1:0]               m_ResultSrc,
  output logic [ADDRESS_WIDTH-1:0] m_rd,
  output logic [DATA_WIDTH-1:0]    m_ALUout,
  output logic [DATA_WIDTH-1:0]    m_WriteData,
  output logic [DATA_WIDTH-1:0]    m_PCPlus4
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [ALUctrl_WIDTH-1:0] OP_ADD   = ALUctrl_WIDTH'(0);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SUB   = ALUctrl_WIDTH'(1);
  localparam logic [ALUctrl_WIDTH-1:0] OP_AND   = ALUctrl_WIDTH'(2);
  localparam logic [ALUctrl_WIDTH-1:0] OP_OR    = ALUctrl_WIDTH'(3);
  localparam logic [ALUctrl_WIDTH-1:0] OP_XOR   = ALUctrl_WIDTH'(4);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SLT   = ALUctrl_WIDTH'(5);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SLTU  = ALUctrl_WIDTH'(6);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SLL   = ALUctrl_WIDTH'(7);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SRL   = ALUctrl_WIDTH'(8);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SRA   = ALUctrl_WIDTH'(9);
  localparam logic [ALUctrl_WIDTH-1:0] OP_MUL   = ALUctrl_WIDTH'(10);
  localparam logic [ALUctrl_WIDTH-1:0] OP_MULHU = ALUctrl_WIDTH'(11);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_next;

  logic [DATA_WIDTH-1:0]     w_fwd_a;
  logic [DATA_WIDTH-1:0]     w_fwd_b;
  logic [DATA_WIDTH-1:0]     w_srca;
  logic [DATA_WIDTH-1:0]     w_srcb;
  logic [SHW-1:0]            w_shamt;
  logic [DATA_WIDTH-1:0]     w_alu_comb;
  logic [DATA_WIDTH-1:0]     w_alu;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic                      w_is_mul;
  logic                      w_mul_start;
  logic                      w_fire;
  logic                      w_zero;
  logic                      w_taken;

  logic [2*DATA_WIDTH-1:0]   r_acc;
  logic [2*DATA_WIDTH-1:0]   r_mcand;
  logic [DATA_WIDTH-1:0]     r_mplier;
  logic [CW-1:0]             r_cnt;
  logic [DATA_WIDTH-1:0]     r_wdata;

  // Forwarding: MEM beats WB, and x0 is never forwarded.
  always_comb begin
    w_fwd_a = RD1;
    if (mem_RegWrite && (mem_rd != '0) && (mem_rd == rs1)) begin
      w_fwd_a = mem_result;
    end else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == rs1)) begin
      w_fwd_a = wb_result;
    end
  end

  always_comb begin
    w_fwd_b = RD2;
    if (mem_RegWrite && (mem_rd != '0) && (mem_rd == rs2)) begin
      w_fwd_b = mem_result;
    end else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == rs2)) begin
      w_fwd_b = wb_result;
    end
  end

  assign w_srca  = w_fwd_a;
  assign w_srcb  = ALUsrc ? ImmOp : w_fwd_b;
  assign w_shamt = w_srcb[SHW-1:0];

  always_comb begin
    w_alu_comb = '0;
    case (ALUctrl)
      OP_ADD:  w_alu_comb = w_srca + w_srcb;
      OP_SUB:  w_alu_comb = w_srca - w_srcb;
      OP_AND:  w_alu_comb = w_srca & w_srcb;
      OP_OR:   w_alu_comb = w_srca | w_srcb;
      OP_XOR:  w_alu_comb = w_srca ^ w_srcb;
      OP_SLT:  w_alu_comb = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
      OP_SLTU: w_alu_comb = {{(DATA_WIDTH-1){1'b0}}, (w_srca < w_srcb)};
      OP_SLL:  w_alu_comb = w_srca << w_shamt;
      OP_SRL:  w_alu_comb = w_srca >> w_shamt;
      OP_SRA:  w_alu_comb = $unsigned($signed(w_srca) >>> w_shamt);
      default: w_alu_comb = '0;
    endcase
  end

  assign w_is_mul    = (ALUctrl == OP_MUL) || (ALUctrl == OP_MULHU);
  assign w_mul_start = ex_valid && w_is_mul;

  // In DONE the product comes from the accumulator. The store data comes from the copy
  // latched at multiply start, so late changes on the forward buses cannot leak in.
  assign w_alu   = (r_state == S_DONE)
                   ? ((ALUctrl == OP_MULHU) ? r_acc[2*DATA_WIDTH-1:DATA_WIDTH] : r_acc[DATA_WIDTH-1:0])
                   : w_alu_comb;
  assign w_wdata = (r_state == S_DONE) ? r_wdata : w_fwd_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ex_ready     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_mul_start) begin
          ex_ready     = 1'b0;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        ex_ready = 1'b0;
        if (r_cnt == CW'(1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_wdata  <= '0;
    end else if ((r_state == S_IDLE) && w_mul_start) begin
      r_acc    <= '0;
      r_mcand  <= {{DATA_WIDTH{1'b0}}, w_srca};
      r_mplier <= w_srcb;
      r_cnt    <= CW'(DATA_WIDTH);
      r_wdata  <= w_fwd_b;
    end else if (r_state == S_BUSY) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  assign w_fire   = ex_valid && ex_ready;
  assign w_zero   = (w_alu == '0);
  assign w_taken  = Branch && (w_zero ^ BranchInv);
  assign PCSrc    = w_fire && (w_taken || Jump);
  assign PCTarget = JALRctrl ? (w_alu & {{(DATA_WIDTH-1){1'b1}}, 1'b0}) : (PC + ImmOp);

  // Bubbles clear only the controls; the data fields keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_RegWrite  <= 1'b0;
      m_MemWrite  <= 1'b0;
      m_ResultSrc <= '0;
      m_rd        <= '0;
      m_ALUout    <= '0;
      m_WriteData <= '0;
      m_PCPlus4   <= '0;
    end else if (w_fire) begin
      m_valid     <= 1'b1;
      m_RegWrite  <= RegWrite;
      m_MemWrite  <= MemWrite;
      m_ResultSrc <= ResultSrc;
      m_rd        <= rd;
      m_ALUout    <= w_alu;
      m_WriteData <= w_wdata;
      m_PCPlus4   <= PCPlus4;
    end else begin
      m_valid     <= 1'b0;
      m_RegWrite  <= 1'b0;
      m_MemWrite  <= 1'b0;
      m_ResultSrc <= '0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard testbench for execute_stage
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        RegWrite, MemWrite, ALUsrc, JALRctrl, Jump, Branch, BranchInv;
  logic [1:0]  ResultSrc;
  logic [3:0]  ALUctrl;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] RD1, RD2, ImmOp, PC, PCPlus4;
  logic        mem_RegWrite, wb_RegWrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        m_valid, m_RegWrite, m_MemWrite;
  logic [1:0]  m_ResultSrc;
  logic [4:0]  m_rd;
  logic [31:0] m_ALUout, m_WriteData, m_PCPlus4;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUsrc(ALUsrc), .JALRctrl(JALRctrl),
    .Jump(Jump), .Branch(Branch), .BranchInv(BranchInv), .ResultSrc(ResultSrc),
    .ALUctrl(ALUctrl), .rs1(rs1), .rs2(rs2), .rd(rd),
    .RD1(RD1), .RD2(RD2), .ImmOp(ImmOp), .PC(PC), .PCPlus4(PCPlus4),
    .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_result(mem_result), .wb_result(wb_result),
    .PCSrc(PCSrc), .PCTarget(PCTarget),
    .m_valid(m_valid), .m_RegWrite(m_RegWrite), .m_MemWrite(m_MemWrite),
    .m_ResultSrc(m_ResultSrc), .m_rd(m_rd), .m_ALUout(m_ALUout),
    .m_WriteData(m_WriteData), .m_PCPlus4(m_PCPlus4)
  );

  typedef struct {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   mon_idx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output alu=%h cyc=%0d", m_ALUout, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (m_RegWrite !== mon_e.rw || m_MemWrite !== mon_e.mw || m_ResultSrc !== mon_e.rs ||
            m_rd !== mon_e.rd || m_ALUout !== mon_e.alu || m_WriteData !== mon_e.wd ||
            m_PCPlus4 !== mon_e.pc4 || cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL result_%0d got rw=%b mw=%b rs=%b rd=%0d alu=%h wd=%h pc4=%h cyc=%0d exp rw=%b mw=%b rs=%b rd=%0d alu=%h wd=%h pc4=%h cyc=%0d",
                   mon_idx, m_RegWrite, m_MemWrite, m_ResultSrc, m_rd, m_ALUout, m_WriteData, m_PCPlus4, cyc,
                   mon_e.rw, mon_e.mw, mon_e.rs, mon_e.rd, mon_e.alu, mon_e.wd, mon_e.pc4, mon_e.cyc);
        end
      end
      mon_idx++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic clr();
    RegWrite = 1'b1; MemWrite = 1'b0; ALUsrc = 1'b0; JALRctrl = 1'b0; Jump = 1'b0;
    Branch = 1'b0; BranchInv = 1'b0; ResultSrc = 2'b00; rd = 5'd7; rs1 = 5'd1; rs2 = 5'd2;
    PC = 32'h100; PCPlus4 = 32'h104; ImmOp = '0; RD1 = '0; RD2 = '0;
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input logic src, input logic [31:0] imm);
    clr();
    ALUctrl = c; RD1 = a; RD2 = b; ALUsrc = src; ImmOp = imm;
  endtask

  // Called at posedge+1; returns at posedge+1 after the slot has been consumed.
  task automatic fire(input logic [31:0] ea, input logic [31:0] ew, input bit is_mul,
                      input bit chk_br, input bit epcsrc, input logic [31:0] etgt);
    exp_t e;
    int   lows;
    int   vhi;
    int   n;
    e.rw = RegWrite; e.mw = MemWrite; e.rs = ResultSrc; e.rd = rd;
    e.alu = ea; e.wd = ew; e.pc4 = PCPlus4;
    e.cyc = cyc + (is_mul ? 34 : 1);
    sb.push_back(e);
    ex_valid = 1'b1;
    lows = 0; vhi = 0; n = 0;
    #1;
    if (chk_br) begin
      chk("pcsrc", 32'(PCSrc), 32'(epcsrc));
      chk("pctarget", PCTarget, etgt);
    end
    while (!ex_ready && n < 60) begin
      lows++;
      @(posedge clk); #2;
      n++;
      if (m_valid) vhi++;
    end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL ready_timeout got=%0d exp<60", n);
    end
    chk("ready_low_cycles", 32'(lows), is_mul ? 32'd33 : 32'd0);
    if (is_mul) chk("bubble_during_mul", 32'(vhi), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ALUctrl = '0;
    mem_RegWrite = 1'b0; wb_RegWrite = 1'b0; mem_rd = '0; wb_rd = '0;
    mem_result = '0; wb_result = '0;
    clr();
    repeat (2) @(posedge clk); #1;
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_alu", m_ALUout, 32'd0);
    chk("reset_m_ctrl", {25'd0, m_RegWrite, m_MemWrite, m_ResultSrc, m_rd == 5'd0}, 32'd1);
    rst_n = 1'b1; #1;
    chk("ready_after_reset", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;

    // forwarding: MEM priority, WB fallback, x0 never forwarded, rs2 forward
    op(4'd0, 32'h99, 32'h33, 1'b1, 32'd1);
    rs1 = 5'd5; rs2 = 5'd3; mem_RegWrite = 1'b1; wb_RegWrite = 1'b1;
    mem_rd = 5'd5; wb_rd = 5'd5; mem_result = 32'h11; wb_result = 32'h22;
    fire(32'h12, 32'h33, 0, 0, 0, 0);
    op(4'd0, 32'h99, 32'h33, 1'b1, 32'd1);
    rs1 = 5'd5; rs2 = 5'd3; mem_RegWrite = 1'b0;
    fire(32'h23, 32'h33, 0, 0, 0, 0);
    op(4'd0, 32'h40, 32'h33, 1'b1, 32'd1);
    rs1 = 5'd0; mem_RegWrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    fire(32'h41, 32'h33, 0, 0, 0, 0);
    op(4'd0, 32'h100, 32'h77, 1'b0, 32'd0);
    rs2 = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5;
    fire(32'h111, 32'h11, 0, 0, 0, 0);
    mem_RegWrite = 1'b0; wb_RegWrite = 1'b0;

    // ALU ops and boundaries
    op(4'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'd1);         fire(32'h0, 32'h0, 0, 0, 0, 0);
    op(4'd9, 32'h8000_0000, 32'h0, 1'b1, 32'h21);        fire(32'hC000_0000, 32'h0, 0, 0, 0, 0);
    op(4'd5, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'd0);         fire(32'h1, 32'h1, 0, 0, 0, 0);
    op(4'd6, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'd0);         fire(32'h0, 32'h1, 0, 0, 0, 0);
    op(4'd1, 32'h3, 32'h5, 1'b0, 32'd0);                 fire(32'hFFFF_FFFE, 32'h5, 0, 0, 0, 0);
    op(4'd7, 32'h1, 32'h0, 1'b1, 32'd31);                fire(32'h8000_0000, 32'h0, 0, 0, 0, 0);
    op(4'd8, 32'h8000_0000, 32'h0, 1'b1, 32'd4);         fire(32'h0800_0000, 32'h0, 0, 0, 0, 0);
    op(4'd2, 32'hF0F0, 32'hFF00, 1'b0, 32'd0);           fire(32'hF000, 32'hFF00, 0, 0, 0, 0);
    op(4'd3, 32'hF0F0, 32'hFF00, 1'b0, 32'd0);           fire(32'hFFF0, 32'hFF00, 0, 0, 0, 0);
    op(4'd4, 32'hF0F0, 32'hFF00, 1'b0, 32'd0);
    MemWrite = 1'b1; RegWrite = 1'b0; rd = 5'd9;         fire(32'h0FF0, 32'hFF00, 0, 0, 0, 0);
    op(4'd12, 32'h5, 32'h6, 1'b0, 32'd0);                fire(32'h0, 32'h6, 0, 0, 0, 0);

    // multiplies, back to back
    op(4'd10, 32'd7, 32'd6, 1'b0, 32'd0);                fire(32'd42, 32'd6, 1, 0, 0, 0);
    op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0); fire(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 0, 0, 0);
    op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0); fire(32'h1, 32'hFFFF_FFFF, 1, 0, 0, 0);

    // forward source sampled only at multiply start
    op(4'd10, 32'h55, 32'h0, 1'b1, 32'd3);
    rs1 = 5'd5; mem_RegWrite = 1'b1; mem_rd = 5'd5; mem_result = 32'h11;
    fork
      fire(32'h33, 32'h0, 1, 0, 0, 0);
      begin
        repeat (3) @(posedge clk);
        #1 mem_result = 32'h99;
      end
    join
    mem_RegWrite = 1'b0;

    // branches and jalr
    op(4'd1, 32'h5, 32'h5, 1'b0, 32'h20);
    Branch = 1'b1;                                       fire(32'h0, 32'h5, 0, 1, 1, 32'h120);
    op(4'd1, 32'h5, 32'h5, 1'b0, 32'h20);
    Branch = 1'b1; BranchInv = 1'b1;                     fire(32'h0, 32'h5, 0, 1, 0, 32'h120);
    op(4'd0, 32'h1003, 32'h77, 1'b1, 32'd0);
    JALRctrl = 1'b1; Jump = 1'b1; ResultSrc = 2'b10; PCPlus4 = 32'h208;
    fire(32'h1003, 32'h77, 0, 1, 1, 32'h1002);
    #1;
    chk("pcsrc_no_valid", 32'(PCSrc), 32'd0);
    @(posedge clk); #1;

    // reset during BUSY aborts the multiply
    op(4'd10, 32'h12345, 32'h3, 1'b0, 32'd0);
    ex_valid = 1'b1;
    repeat (11) @(posedge clk); #1;
    rst_n = 1'b0; ex_valid = 1'b0; #1;
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_m_alu", m_ALUout, 32'd0);
    chk("abort_m_wdata", m_WriteData, 32'd0);
    chk("abort_m_pc4", m_PCPlus4, 32'd0);
    chk("abort_m_rd", 32'(m_rd), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("abort_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    op(4'd0, 32'd2, 32'd3, 1'b0, 32'd0);                 fire(32'd5, 32'd3, 0, 0, 0, 0);

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Pipelined execute stage for the five-stage RV32 core. It takes the decoded ID/EX slot and resolves RAW hazards by forwarding from MEM and WB. It computes ALU results, including a multi-cycle shift-add multiply, and resolves branches and jumps. Results go into a registered EX/MEM slot, and the block back-pressures decode while a multiply is in progress.

## Interface
- DATA_WIDTH, 32, datapath width; power of two, at least 8
- ADDRESS_WIDTH, 5, register index width
- ALUctrl_WIDTH, 4, ALU opcode width
---
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  ID/EX slot holds an instruction
- ex_ready  out  1  EX consumes the slot this cycle; upstream holds all inputs stable while low
- RegWrite, MemWrite, ALUsrc, JALRctrl, Jump, Branch, BranchInv  in  1 each  decoded controls
- ResultSrc  in  2  00 ALU, 01 ReadData, 10 PCPlus4
- ALUctrl  in  ALUctrl_WIDTH  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 mul, 11 mulhu; 12-15 give result 0
- rs1, rs2, rd  in  ADDRESS_WIDTH  register indices
- RD1, RD2, ImmOp, PC, PCPlus4  in  DATA_WIDTH  operands from decode
- mem_RegWrite, wb_RegWrite  in  1  forward-source write enables
- mem_rd, wb_rd  in  ADDRESS_WIDTH  forward-source destinations
- mem_result, wb_result  in  DATA_WIDTH  forward-source data
- PCSrc  out  1  redirect fetch, combinational
- PCTarget  out  DATA_WIDTH  redirect address, combinational
- m_valid, m_RegWrite, m_MemWrite  out  1  EX/MEM registered controls
- m_ResultSrc  out  2  registered ResultSrc
- m_rd  out  ADDRESS_WIDTH  registered rd
- m_ALUout, m_WriteData, m_PCPlus4  out  DATA_WIDTH  registered ALU result, forwarded rs2, and PCPlus4

## Operation
- Forwarding applies per source independently.
  - Use mem_result if mem_RegWrite, mem_rd != 0 and mem_rd == rsN.
  - Otherwise use wb_result under the same rule with wb_*.
  - Otherwise use RDn.
  - MEM has priority over WB. Index 0 is never forwarded.
- SrcA is forwarded rs1. SrcB is ImmOp if ALUsrc, else forwarded rs2. m_WriteData is always forwarded rs2.
- Arithmetic wraps modulo 2^DATA_WIDTH.
  - slt is signed, sltu is unsigned; both return 0 or 1.
  - Shifts use SrcB[log2(DATA_WIDTH)-1:0].
  - mul returns the low half of the unsigned 2·DATA_WIDTH-bit product; mulhu returns the high half.
- Branch resolution:
  - Zero = (ALU result == 0).
  - taken = Branch & (Zero ^ BranchInv).
  - PCSrc = ex_valid & ex_ready & (taken | Jump).
  - PCTarget = JALRctrl ? (ALU result & ~1) : PC + ImmOp.
  - PCTarget is driven whenever ex_valid is high, irrespective of PCSrc.
- FSM with states IDLE, BUSY and DONE.
  - IDLE: if ex_valid and ALUctrl is 10 or 11, latch forwarded SrcA and SrcB, clear the 2·DATA_WIDTH accumulator, load cnt = DATA_WIDTH, drive ex_ready = 0 and go to BUSY. For any other op, ex_ready = 1.
  - BUSY: each cycle, if the multiplier LSB is set, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and decrement cnt. When cnt reaches 1 on this edge, go to DONE. ex_ready = 0 throughout.
  - DONE: ex_ready = 1. Select the low or high half per ALUctrl, go to IDLE at the edge.
- EX/MEM capture at each edge:
  - If ex_valid & ex_ready, load all m_* with m_valid = 1.
  - Otherwise load a bubble: m_valid and all m_* controls = 0.
- Forward sources are sampled only when the multiply starts. Later changes on mem_*/wb_* do not affect an in-flight multiply.

## Timing
- Reset (async assert, sync release): every m_* output = 0, FSM = IDLE, cnt = 0, accumulator = 0. ex_ready = 1 once reset releases.
- Non-multiply ops have latency 1: inputs in cycle t appear on m_* in cycle t+1.
- Multiply accepted in IDLE at cycle t:
  - ex_ready is low for cycles t..t+DATA_WIDTH (DATA_WIDTH+1 cycles).
  - DONE is cycle t+DATA_WIDTH+1.
  - The result appears on m_* in cycle t+DATA_WIDTH+2.
- Reset asserted during BUSY or DONE aborts the multiply. Nothing is written to EX/MEM, and the instruction is lost.
- ex_valid low in IDLE produces a bubble and no state change.

## Test plan
- Forwarding: rs1 = 5, mem_rd = wb_rd = 5, both write enables set, mem_result = 0x11, wb_result = 0x22, add with imm 1 -> m_ALUout = 0x12. With rs1 = 0 and mem_rd = 0 -> RD1 is used.
- Wrap and shift: 0xFFFFFFFF + 1 -> 0. sra of 0x80000000 by SrcB = 0x21 -> shift by 1 -> 0xC0000000. slt(-1, 1) = 1, sltu(-1, 1) = 0.
- Multiply: 7 mul 6 at cycle t -> ex_ready low for 33 cycles, m_ALUout = 42 with m_valid in cycle t+34. mulhu 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. m_valid = 0 for cycles t+1..t+33.
- Branch: Branch = 1, BranchInv = 0, equal operands, PC = 0x100, ImmOp = 0x20 -> PCSrc = 1, PCTarget = 0x120. Same with BranchInv = 1 -> PCSrc = 0.
- JALR: JALRctrl = Jump = 1, SrcA = 0x1003, imm 0 -> PCTarget = 0x1002. ResultSrc = 10 -> m_PCPlus4 registered.
- Reset mid-multiply: assert rst_n low 10 cycles into BUSY -> all m_* = 0 immediately, ex_ready = 1 after release, and the next add completes in 1 cycle.
